// File: rtl/suprloco_rom_loader_if.sv
// Download-side bus between hps_io and the ROM loader, plus the ROM BRAM write port it drives.
// The master is hps_io plus the BRAMs; the slave is the loader.
interface suprloco_rom_loader_if;
    logic        ioctl_download;
    logic [15:0] ioctl_index;
    logic [26:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic        ioctl_wait;
    logic [15:0] o_ROM_ADDR;
    logic [7:0]  o_ROM_DATA;
    logic [4:0]  o_ROM_CS;
    logic        o_ROM_WR;

    modport master (
        output ioctl_download, ioctl_index, ioctl_addr, ioctl_data, ioctl_wr,
        input  ioctl_wait, o_ROM_ADDR, o_ROM_DATA, o_ROM_CS, o_ROM_WR
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_addr, ioctl_data, ioctl_wr,
        output ioctl_wait, o_ROM_ADDR, o_ROM_DATA, o_ROM_CS, o_ROM_WR
    );
endinterface

// File: rtl/suprloco_rom_loader.sv
// Steers the hps_io download stream into the Super Locomotive ROM/PROM BRAMs,
// captures the DIP bank and holds the game board in reset until the ROM set is loaded.
module suprloco_rom_loader #(
    parameter logic [15:0] ROM_INDEX   = 16'd0,
    parameter logic [15:0] DIP_INDEX   = 16'd254,
    parameter int          WAIT_CYC    = 2,
    parameter int          RST_HOLD    = 16,
    parameter logic [23:0] DIP_DEFAULT = 24'hFFFFFF
) (
    input  logic                        i_EMU_MCLK,
    input  logic                        i_EMU_INITRST,
    suprloco_rom_loader_if.slave        bus,
    output logic [23:0]                 o_DIPSW,
    output logic                        o_CORE_RST,
    output logic                        o_LOAD_DONE,
    output logic                        o_MAP_ERR
);

    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);
    localparam logic [7:0] HOLD_INIT = 8'(RST_HOLD);

    typedef enum logic [1:0] {IDLE, WRITE, WAIT} state_t;

    state_t      state, state_next;
    logic [3:0]  wait_cnt;
    logic [7:0]  hold_cnt;
    logic        hold_active;
    logic        dl_prev;
    logic [4:0]  map_cs;
    logic [15:0] map_base;
    logic        mapped;
    logic [15:0] rel_addr;
    logic        rom_sel, dip_sel;
    logic        accept, unmapped_err, busy_err;
    logic        dl_rise, dl_fall;

    // Region decode; the 16-bit subtraction equals the truncated full-width offset.
    always_comb begin
        map_cs   = '0;
        map_base = '0;
        mapped   = 1'b1;
        if (bus.ioctl_addr < 27'h0C000) begin
            map_cs = 5'b00001; map_base = 16'h0000;
        end else if (bus.ioctl_addr < 27'h0E000) begin
            map_cs = 5'b00010; map_base = 16'hC000;
        end else if (bus.ioctl_addr < 27'h1A000) begin
            map_cs = 5'b00100; map_base = 16'hE000;
        end else if (bus.ioctl_addr < 27'h1C000) begin
            map_cs = 5'b01000; map_base = 16'hA000;
        end else if (bus.ioctl_addr < 27'h1C400) begin
            map_cs = 5'b10000; map_base = 16'hC000;
        end else begin
            mapped = 1'b0;
        end
    end

    assign rel_addr     = bus.ioctl_addr[15:0] - map_base;
    assign rom_sel      = bus.ioctl_download && (bus.ioctl_index == ROM_INDEX);
    assign dip_sel      = bus.ioctl_download && (bus.ioctl_index == DIP_INDEX);
    assign accept       = bus.ioctl_wr && rom_sel && mapped && (state == IDLE);
    assign unmapped_err = bus.ioctl_wr && rom_sel && !mapped && (state == IDLE);
    assign busy_err     = bus.ioctl_wr && (state != IDLE);
    assign dl_rise      = bus.ioctl_download && !dl_prev && (bus.ioctl_index == ROM_INDEX);
    assign dl_fall      = !bus.ioctl_download && dl_prev && (bus.ioctl_index == ROM_INDEX);

    always_ff @(posedge i_EMU_MCLK or posedge i_EMU_INITRST) begin
        if (i_EMU_INITRST) state <= IDLE;
        else               state <= state_next;
    end

    always_comb begin
        state_next     = state;
        bus.o_ROM_WR   = 1'b0;
        bus.ioctl_wait = 1'b0;
        case (state)
            IDLE:    if (accept) state_next = WRITE;
            WRITE: begin
                bus.o_ROM_WR   = 1'b1;
                bus.ioctl_wait = 1'b1;
                state_next     = (WAIT_CYC > 0) ? WAIT : IDLE;
            end
            WAIT: begin
                bus.ioctl_wait = 1'b1;
                if (wait_cnt == 4'd0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Write port latches only on accept, so it holds its last value between writes.
    always_ff @(posedge i_EMU_MCLK or posedge i_EMU_INITRST) begin
        if (i_EMU_INITRST) begin
            bus.o_ROM_ADDR <= '0;
            bus.o_ROM_DATA <= '0;
            bus.o_ROM_CS   <= '0;
            wait_cnt       <= '0;
        end else begin
            if (accept) begin
                bus.o_ROM_ADDR <= rel_addr;
                bus.o_ROM_DATA <= bus.ioctl_data;
                bus.o_ROM_CS   <= map_cs;
            end
            if (state == WRITE)
                wait_cnt <= WAIT_LOAD;
            else if (state == WAIT && wait_cnt != 4'd0)
                wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // The hold countdown waits for any in-flight write to drain before running.
    always_ff @(posedge i_EMU_MCLK or posedge i_EMU_INITRST) begin
        if (i_EMU_INITRST) begin
            o_CORE_RST  <= 1'b1;
            o_LOAD_DONE <= 1'b0;
            o_MAP_ERR   <= 1'b0;
            o_DIPSW     <= DIP_DEFAULT;
            hold_cnt    <= HOLD_INIT;
            hold_active <= 1'b0;
            dl_prev     <= 1'b0;
        end else begin
            dl_prev <= bus.ioctl_download;
            if (dl_rise) begin
                o_CORE_RST  <= 1'b1;
                o_LOAD_DONE <= 1'b0;
                o_MAP_ERR   <= 1'b0;
                hold_cnt    <= HOLD_INIT;
                hold_active <= 1'b0;
            end else begin
                if (dl_fall) begin
                    o_LOAD_DONE <= 1'b1;
                    hold_active <= 1'b1;
                end
                if (hold_active && state == IDLE) begin
                    if (hold_cnt <= 8'd1) begin
                        hold_cnt    <= 8'd0;
                        o_CORE_RST  <= 1'b0;
                        hold_active <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
            end
            if (unmapped_err || busy_err) o_MAP_ERR <= 1'b1;
            if (bus.ioctl_wr && dip_sel && bus.ioctl_addr < 27'd3) begin
                case (bus.ioctl_addr[1:0])
                    2'd0:    o_DIPSW[7:0]   <= bus.ioctl_data;
                    2'd1:    o_DIPSW[15:8]  <= bus.ioctl_data;
                    2'd2:    o_DIPSW[23:16] <= bus.ioctl_data;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_suprloco_rom_loader.sv
// Self-checking bench for suprloco_rom_loader: random ROM/DIP traffic against a
// region-table reference model, plus reset, hold timing and error-flag scenarios.
module tb_suprloco_rom_loader;

    localparam int WAIT_CYC = 2;
    localparam int RST_HOLD = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] dipsw;
    logic        core_rst, load_done, map_err;
    int          vectors = 0;
    int          miscompares = 0;

    typedef struct packed {
        logic [4:0]  cs;
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_rec_t;

    wr_rec_t    obs_q[$];
    logic [7:0] dip_model[3];

    suprloco_rom_loader_if bus();

    suprloco_rom_loader #(
        .ROM_INDEX(16'd0), .DIP_INDEX(16'd254), .WAIT_CYC(WAIT_CYC),
        .RST_HOLD(RST_HOLD), .DIP_DEFAULT(24'hFFFFFF)
    ) dut (
        .i_EMU_MCLK(clk), .i_EMU_INITRST(rst), .bus(bus),
        .o_DIPSW(dipsw), .o_CORE_RST(core_rst), .o_LOAD_DONE(load_done), .o_MAP_ERR(map_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (bus.o_ROM_WR === 1'b1)
            obs_q.push_back(wr_rec_t'{bus.o_ROM_CS, bus.o_ROM_ADDR, bus.o_ROM_DATA});

    // Reference map as a base/size table.
    function automatic void ref_region(input int a, output logic [4:0] cs, output logic [15:0] off);
        int base[5] = '{'h00000, 'h0C000, 'h0E000, 'h1A000, 'h1C000};
        int size[5] = '{'h0C000, 'h02000, 'h0C000, 'h02000, 'h00400};
        cs  = '0;
        off = '0;
        for (int i = 0; i < 5; i++)
            if (a >= base[i] && a < base[i] + size[i]) begin
                cs  = 5'(1 << i);
                off = 16'(a - base[i]);
            end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rom(input logic [26:0] a, input logic [7:0] d);
        tick();
        bus.ioctl_addr = a;
        bus.ioctl_data = d;
        bus.ioctl_wr   = 1'b1;
        tick();
        bus.ioctl_wr = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (bus.ioctl_wait !== 1'b1) break;
            tick();
        end
        if (bus.ioctl_wait !== 1'b0) begin
            vectors++; miscompares++;
            $display("[TB] FAIL wait_timeout: ioctl_wait=%b required 0", bus.ioctl_wait);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 16'd0;
        bus.ioctl_addr     = '0;
        bus.ioctl_data     = '0;
        bus.ioctl_wr       = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        vectors++; if (core_rst !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_core_rst: got %b want 1", core_rst); end
        vectors++; if (dipsw !== 24'hFFFFFF) begin miscompares++; $display("[TB] FAIL reset_dipsw: got %h want FFFFFF", dipsw); end
        vectors++; if (load_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_load_done: got %b want 0", load_done); end
        vectors++; if (bus.ioctl_wait !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wait: got %b want 0", bus.ioctl_wait); end
        vectors++; if (bus.o_ROM_WR !== 1'b0 || bus.o_ROM_CS !== 5'b0) begin miscompares++; $display("[TB] FAIL reset_rom_port: wr %b cs %b want 0/00000", bus.o_ROM_WR, bus.o_ROM_CS); end
        vectors++; if (map_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_map_err: got %b want 0", map_err); end
    endtask

    task automatic test_single_write();
        int wait_cycles;
        tick();
        bus.ioctl_download = 1'b1;
        bus.ioctl_index    = 16'd0;
        tick();
        obs_q.delete();
        bus.ioctl_addr = 27'h0C005;
        bus.ioctl_data = 8'hA5;
        bus.ioctl_wr   = 1'b1;
        tick();
        bus.ioctl_wr = 1'b0;
        @(negedge clk);
        vectors++; if (bus.o_ROM_WR !== 1'b1) begin miscompares++; $display("[TB] FAIL single_wr: got %b want 1", bus.o_ROM_WR); end
        vectors++; if (bus.o_ROM_CS !== 5'b00010) begin miscompares++; $display("[TB] FAIL single_cs: got %b want 00010", bus.o_ROM_CS); end
        vectors++; if (bus.o_ROM_ADDR !== 16'h0005) begin miscompares++; $display("[TB] FAIL single_addr: got %h want 0005", bus.o_ROM_ADDR); end
        vectors++; if (bus.o_ROM_DATA !== 8'hA5) begin miscompares++; $display("[TB] FAIL single_data: got %h want A5", bus.o_ROM_DATA); end
        wait_cycles = (bus.ioctl_wait === 1'b1) ? 1 : 0;
        repeat (7) begin
            @(negedge clk);
            if (bus.ioctl_wait === 1'b1) wait_cycles++;
        end
        vectors++; if (wait_cycles != WAIT_CYC + 1) begin miscompares++; $display("[TB] FAIL single_wait_len: got %0d want %0d", wait_cycles, WAIT_CYC + 1); end
        vectors++; if (obs_q.size() != 1) begin miscompares++; $display("[TB] FAIL single_strobes: got %0d want 1", obs_q.size()); end
        vectors++; if (bus.o_ROM_CS !== 5'b00010 || bus.o_ROM_DATA !== 8'hA5) begin miscompares++; $display("[TB] FAIL single_hold: cs %b data %h want 00010/A5", bus.o_ROM_CS, bus.o_ROM_DATA); end
    endtask

    task automatic test_full_stream();
        int          addrs[$];
        int          bounds[6] = '{'h00000, 'h0C000, 'h0E000, 'h1A000, 'h1C000, 'h1C400};
        logic [4:0]  exp_cs;
        logic [15:0] exp_off;
        logic [7:0]  d;
        wr_rec_t     got;
        for (int b = 0; b < 6; b++)
            for (int k = -3; k <= 2; k++)
                if (bounds[b] + k >= 0 && bounds[b] + k < 'h1C400) addrs.push_back(bounds[b] + k);
        repeat (150) addrs.push_back(int'($urandom_range(0, 'h1C3FF)));
        foreach (addrs[i]) begin
            d = 8'($urandom);
            repeat ($urandom_range(0, 2)) tick();
            obs_q.delete();
            send_rom(27'(addrs[i]), d);
            @(negedge clk);
            ref_region(addrs[i], exp_cs, exp_off);
            vectors++;
            if (obs_q.size() != 1) begin
                miscompares++;
                $display("[TB] FAIL stream_count @%h: got %0d strobes want 1", addrs[i], obs_q.size());
            end else begin
                got = obs_q.pop_front();
                if (got.cs !== exp_cs || got.addr !== exp_off || got.data !== d) begin
                    miscompares++;
                    $display("[TB] FAIL stream_write @%h: got cs %b addr %h data %h want cs %b addr %h data %h",
                             addrs[i], got.cs, got.addr, got.data, exp_cs, exp_off, d);
                end
            end
        end
        vectors++; if (map_err !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_map_err: got %b want 0", map_err); end
        vectors++; if (core_rst !== 1'b1 || load_done !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_status: core_rst %b load_done %b want 1/0", core_rst, load_done); end
    endtask

    task automatic test_load_done();
        int n;
        tick();
        bus.ioctl_download = 1'b0;
        tick();
        @(negedge clk);
        vectors++; if (load_done !== 1'b1) begin miscompares++; $display("[TB] FAIL done_flag: got %b want 1", load_done); end
        vectors++; if (core_rst !== 1'b1) begin miscompares++; $display("[TB] FAIL done_rst_early: got %b want 1", core_rst); end
        n = 0;
        while (core_rst === 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        vectors++; if (n != RST_HOLD) begin miscompares++; $display("[TB] FAIL hold_len: got %0d cycles want %0d", n, RST_HOLD); end
        tick();
        bus.ioctl_download = 1'b1;
        tick();
        @(negedge clk);
        vectors++; if (core_rst !== 1'b1 || load_done !== 1'b0) begin miscompares++; $display("[TB] FAIL restart: core_rst %b load_done %b want 1/0", core_rst, load_done); end
    endtask

    task automatic test_map_err();
        bit          saw_activity;
        int          a;
        logic [4:0]  exp_cs;
        logic [15:0] exp_off;
        logic [7:0]  d;
        wr_rec_t     got;
        obs_q.delete();
        tick();
        bus.ioctl_addr = 27'h1C400;
        bus.ioctl_wr   = 1'b1;
        tick();
        bus.ioctl_wr = 1'b0;
        saw_activity = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.ioctl_wait !== 1'b0 || bus.o_ROM_WR !== 1'b0) saw_activity = 1'b1;
        end
        vectors++; if (saw_activity || obs_q.size() != 0) begin miscompares++; $display("[TB] FAIL unmapped_quiet: activity %b strobes %0d want 0/0", saw_activity, obs_q.size()); end
        vectors++; if (map_err !== 1'b1) begin miscompares++; $display("[TB] FAIL unmapped_flag: got %b want 1", map_err); end

        tick();
        bus.ioctl_download = 1'b0;
        tick();
        bus.ioctl_download = 1'b1;
        tick();
        vectors++; if (map_err !== 1'b0) begin miscompares++; $display("[TB] FAIL map_err_clear: got %b want 0", map_err); end

        obs_q.delete();
        a = int'($urandom_range(0, 'h1C3FF));
        d = 8'($urandom);
        bus.ioctl_addr = 27'(a);
        bus.ioctl_data = d;
        bus.ioctl_wr   = 1'b1;
        tick();
        bus.ioctl_wr = 1'b0;
        tick();
        bus.ioctl_addr = 27'(int'($urandom_range(0, 'h1C3FF)));
        bus.ioctl_data = 8'($urandom);
        bus.ioctl_wr   = 1'b1;
        tick();
        bus.ioctl_wr = 1'b0;
        repeat (6) tick();
        ref_region(a, exp_cs, exp_off);
        vectors++;
        if (obs_q.size() != 1) begin
            miscompares++;
            $display("[TB] FAIL busy_drop: got %0d strobes want 1", obs_q.size());
        end else begin
            got = obs_q.pop_front();
            if (got.cs !== exp_cs || got.addr !== exp_off || got.data !== d) begin
                miscompares++;
                $display("[TB] FAIL busy_first: got %b/%h/%h want %b/%h/%h", got.cs, got.addr, got.data, exp_cs, exp_off, d);
            end
        end
        vectors++; if (map_err !== 1'b1) begin miscompares++; $display("[TB] FAIL busy_flag: got %b want 1", map_err); end
    endtask

    task automatic test_dip();
        logic [7:0] fixed_bytes[4] = '{8'h12, 8'h34, 8'h56, 8'h78};
        int         a;
        logic [7:0] d;
        int         n;
        tick();
        bus.ioctl_download = 1'b0;
        n = 0;
        while (core_rst === 1'b1 && n < 300) begin
            tick();
            n++;
        end
        dip_model = '{8'hFF, 8'hFF, 8'hFF};
        bus.ioctl_index = 16'd254;
        tick();
        bus.ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.ioctl_addr = 27'(i);
            bus.ioctl_data = fixed_bytes[i];
            bus.ioctl_wr   = 1'b1;
            tick();
            bus.ioctl_wr = 1'b0;
            if (i < 3) dip_model[i] = fixed_bytes[i];
            @(negedge clk);
            vectors++; if (dipsw !== {dip_model[2], dip_model[1], dip_model[0]} || bus.ioctl_wait !== 1'b0) begin miscompares++; $display("[TB] FAIL dip_byte%0d: got %h wait %b want %h wait 0", i, dipsw, bus.ioctl_wait, {dip_model[2], dip_model[1], dip_model[0]}); end
            tick();
        end
        vectors++; if (dipsw !== 24'h563412) begin miscompares++; $display("[TB] FAIL dip_fixed: got %h want 563412", dipsw); end
        repeat (6) begin
            a = int'($urandom_range(0, 5));
            d = 8'($urandom);
            bus.ioctl_addr = 27'(a);
            bus.ioctl_data = d;
            bus.ioctl_wr   = 1'b1;
            tick();
            bus.ioctl_wr = 1'b0;
            if (a < 3) dip_model[a] = d;
            @(negedge clk);
            vectors++; if (dipsw !== {dip_model[2], dip_model[1], dip_model[0]}) begin miscompares++; $display("[TB] FAIL dip_random @%0d: got %h want %h", a, dipsw, {dip_model[2], dip_model[1], dip_model[0]}); end
        end
        tick();
        bus.ioctl_download = 1'b0;
        tick();
        bus.ioctl_index = 16'd0;
        tick();
        vectors++; if (core_rst !== 1'b0 || load_done !== 1'b1) begin miscompares++; $display("[TB] FAIL dip_status: core_rst %b load_done %b want 0/1", core_rst, load_done); end
    endtask

    task automatic test_reset_mid_wait();
        tick();
        bus.ioctl_download = 1'b1;
        tick();
        bus.ioctl_addr = 27'h00100;
        bus.ioctl_data = 8'h5A;
        bus.ioctl_wr   = 1'b1;
        tick();
        bus.ioctl_wr = 1'b0;
        tick();
        vectors++; if (bus.ioctl_wait !== 1'b1) begin miscompares++; $display("[TB] FAIL pre_reset_wait: got %b want 1", bus.ioctl_wait); end
        #2;
        rst = 1'b1;
        #1;
        vectors++; if (bus.ioctl_wait !== 1'b0 || bus.o_ROM_WR !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_handshake: wait %b wr %b want 0/0", bus.ioctl_wait, bus.o_ROM_WR); end
        vectors++; if (bus.o_ROM_CS !== 5'b0 || bus.o_ROM_ADDR !== 16'h0 || bus.o_ROM_DATA !== 8'h0) begin miscompares++; $display("[TB] FAIL abort_rom_port: cs %b addr %h data %h want zeros", bus.o_ROM_CS, bus.o_ROM_ADDR, bus.o_ROM_DATA); end
        vectors++; if (dipsw !== 24'hFFFFFF || core_rst !== 1'b1 || load_done !== 1'b0 || map_err !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_status: dip %h rst %b done %b err %b want FFFFFF/1/0/0", dipsw, core_rst, load_done, map_err); end
        tick();
        bus.ioctl_download = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_full_stream();
        test_load_done();
        test_map_err();
        test_dip();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
